// File: rtl/erx_reset_seq.sv
// RX-side clock/reset sequencer: brings up RX PLL and IDELAYCTRL in order, releases the
// RX core once the link clock toggles, and tears the path down on lock or clock loss.
module erx_reset_seq #(
  parameter int RCW     = 8,
  parameter int TIMEOUT = 4
) (
  input  logic       sys_clk,
  input  logic       sys_reset,
  input  logic       soft_reset,
  input  logic       pll_locked,
  input  logic       idelay_rdy,
  input  logic       rx_toggle,
  input  logic       status_clear,
  output logic       pll_reset,
  output logic       idelay_reset,
  output logic       rx_nreset,
  output logic       rx_active,
  output logic       lock_lost,
  output logic       clk_lost,
  output logic [2:0] state
);

  // state          | meaning
  // RX_RESET_ALL   | PLL and IDELAYCTRL held in reset
  // RX_WAIT_LOCK   | PLL released, waiting for lock
  // RX_IDELAY_RST  | IDELAYCTRL reset held one heartbeat period
  // RX_WAIT_RDY    | IDELAYCTRL released, waiting for ready
  // RX_WAIT_ACT    | waiting for an RX clock toggle edge
  // RX_ACTIVE      | RX core out of reset, monitoring lock and clock
  typedef enum logic [2:0] {
    RX_RESET_ALL  = 3'b000,
    RX_WAIT_LOCK  = 3'b001,
    RX_IDELAY_RST = 3'b010,
    RX_WAIT_RDY   = 3'b011,
    RX_WAIT_ACT   = 3'b100,
    RX_ACTIVE     = 3'b101
  } state_t;

  localparam logic [3:0] TIMEOUT_C = 4'(TIMEOUT);
  localparam logic [3:0] MISS_MAX  = 4'd15;

  logic [RCW-1:0] counter_q, counter_d;
  logic           heartbeat_q, heartbeat_d;
  logic           lock_s1_q, lock_s1_d, lock_s2_q, lock_s2_d;
  logic           rdy_s1_q, rdy_s1_d, rdy_s2_q, rdy_s2_d;
  logic           tog_s1_q, tog_s1_d, tog_s2_q, tog_s2_d, tog_hist_q, tog_hist_d;
  logic           edge_seen_q, edge_seen_d;
  logic [3:0]     miss_q, miss_d;
  state_t         state_q, state_d;
  logic           lock_lost_q, lock_lost_d;
  logic           clk_lost_q, clk_lost_d;

  logic           toggle_edge;
  logic [3:0]     miss_inc;
  logic           clk_timeout;
  logic           set_lock_lost, set_clk_lost;

  always_comb begin
    counter_d   = counter_q + 1'b1;
    heartbeat_d = (counter_q == '0);
    lock_s1_d   = pll_locked;
    lock_s2_d   = lock_s1_q;
    rdy_s1_d    = idelay_rdy;
    rdy_s2_d    = rdy_s1_q;
    tog_s1_d    = rx_toggle;
    tog_s2_d    = tog_s1_q;
    tog_hist_d  = tog_s2_q;
  end

  // An edge landing on the heartbeat cycle must survive the clear.
  always_comb begin
    toggle_edge = tog_s2_q ^ tog_hist_q;
    edge_seen_d = toggle_edge | (edge_seen_q & ~heartbeat_q);
    miss_inc    = (miss_q == MISS_MAX) ? miss_q : miss_q + 4'd1;
    clk_timeout = heartbeat_q && !edge_seen_q && (miss_inc >= TIMEOUT_C);
    miss_d      = miss_q;
    if (state_q != RX_ACTIVE) begin
      miss_d = 4'd0;
    end else if (heartbeat_q) begin
      miss_d = edge_seen_q ? 4'd0 : miss_inc;
    end
  end

  always_comb begin
    state_d       = state_q;
    set_lock_lost = 1'b0;
    set_clk_lost  = 1'b0;
    case (state_q)
      RX_RESET_ALL: begin
        if (heartbeat_q && !soft_reset) state_d = RX_WAIT_LOCK;
      end
      RX_WAIT_LOCK: begin
        if (heartbeat_q) begin
          if (soft_reset)     state_d = RX_RESET_ALL;
          else if (lock_s2_q) state_d = RX_IDELAY_RST;
        end
      end
      RX_IDELAY_RST: begin
        if (heartbeat_q) state_d = soft_reset ? RX_RESET_ALL : RX_WAIT_RDY;
      end
      RX_WAIT_RDY: begin
        if (heartbeat_q) begin
          if (soft_reset)    state_d = RX_RESET_ALL;
          else if (rdy_s2_q) state_d = RX_WAIT_ACT;
        end
      end
      RX_WAIT_ACT: begin
        if (heartbeat_q) begin
          if (soft_reset)       state_d = RX_RESET_ALL;
          else if (edge_seen_q) state_d = RX_ACTIVE;
        end
      end
      RX_ACTIVE: begin
        if (!lock_s2_q) begin
          state_d       = RX_RESET_ALL;
          set_lock_lost = 1'b1;
        end else if (clk_timeout) begin
          state_d      = RX_RESET_ALL;
          set_clk_lost = 1'b1;
        end else if (heartbeat_q && soft_reset) begin
          state_d = RX_RESET_ALL;
        end
      end
      default: state_d = RX_RESET_ALL;
    endcase
    lock_lost_d = set_lock_lost | (lock_lost_q & ~status_clear);
    clk_lost_d  = set_clk_lost  | (clk_lost_q  & ~status_clear);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      counter_q   <= '0;
      heartbeat_q <= 1'b0;
      lock_s1_q   <= 1'b0;
      lock_s2_q   <= 1'b0;
      rdy_s1_q    <= 1'b0;
      rdy_s2_q    <= 1'b0;
      tog_s1_q    <= 1'b0;
      tog_s2_q    <= 1'b0;
      tog_hist_q  <= 1'b0;
      edge_seen_q <= 1'b0;
      miss_q      <= 4'd0;
      state_q     <= RX_RESET_ALL;
      lock_lost_q <= 1'b0;
      clk_lost_q  <= 1'b0;
    end else begin
      counter_q   <= counter_d;
      heartbeat_q <= heartbeat_d;
      lock_s1_q   <= lock_s1_d;
      lock_s2_q   <= lock_s2_d;
      rdy_s1_q    <= rdy_s1_d;
      rdy_s2_q    <= rdy_s2_d;
      tog_s1_q    <= tog_s1_d;
      tog_s2_q    <= tog_s2_d;
      tog_hist_q  <= tog_hist_d;
      edge_seen_q <= edge_seen_d;
      miss_q      <= miss_d;
      state_q     <= state_d;
      lock_lost_q <= lock_lost_d;
      clk_lost_q  <= clk_lost_d;
    end
  end

  assign pll_reset    = (state_q == RX_RESET_ALL);
  assign idelay_reset = (state_q == RX_RESET_ALL) || (state_q == RX_WAIT_LOCK) ||
                        (state_q == RX_IDELAY_RST);
  assign rx_nreset    = (state_q == RX_ACTIVE);
  assign rx_active    = (state_q == RX_ACTIVE);
  assign lock_lost    = lock_lost_q;
  assign clk_lost     = clk_lost_q;
  assign state        = state_q;

endmodule
